uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter between up to `N_REQ` byte-stream requesters, such as the debug dump engine and the command-acknowledge responder. Grants are round-robin and locked per frame: a requester keeps the transmitter from its first byte until it sends a byte flagged `last`. Each frame is prefixed with one header byte that identifies the source. The block sits between the requesters and the `uart_tx` instance and drives `tx_start`/`tx_data` with the same one-cycle-start / `tx_done` handshake the UART already uses.

## Interface
- `NB_DATA`, 8: UART byte width.
- `N_REQ`, 4: number of requesters, 1..16.
- `TIMEOUT`, 4096: maximum number of cycles to wait for `i_tx_done` after a start.
- `i_clk` in 1: clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_req_valid` in N_REQ: requester *i* has a byte available.
- `i_req_data` in N_REQ*NB_DATA: byte of requester *i* on bits `[i*NB_DATA +: NB_DATA]`.
- `i_req_last` in N_REQ: the byte is the final byte of its frame.
- `o_req_ready` out N_REQ: byte is accepted when `valid & ready`.
- `o_tx_data` out NB_DATA: byte to the UART.
- `o_tx_start` out 1: one-cycle start pulse.
- `i_tx_done` in 1: UART finished the current byte.
- `o_grant` out N_REQ: one-hot owner of the transmitter; all zeros when idle.
- `o_busy` out 1: a frame is in progress.
- `o_timeout` out 1: sticky flag, set when a `tx_done` wait expires.

## Operation
**States:** IDLE, WAIT, FETCH.

**IDLE**
- `o_grant` = 0.
- If any `i_req_valid` is high, choose the first valid index at or after `rr_ptr`, searching circularly.
- At the next edge:
  - `o_grant` = one-hot of the winner.
  - `rr_ptr` = winner + 1, modulo N_REQ.
  - `o_tx_data` = `{4'hA, id[3:0]}`.
  - `o_tx_start` = 1.
  - `last_q` = 0.
  - Go to WAIT.
- The header consumes no requester byte.

**WAIT**
- Count cycles.
- On `i_tx_done`:
  - If `last_q` is set, go to IDLE and clear `o_grant`.
  - Otherwise go to FETCH.
- If the count reaches `TIMEOUT` without `i_tx_done`:
  - Set `o_timeout`.
  - Proceed exactly as if `i_tx_done` had arrived; the byte is counted as sent.

**FETCH**
- `o_req_ready[g]` = 1 for the granted index only; it is combinational from state and grant.
- If `i_req_valid[g]` is high, at the next edge:
  - `o_tx_data` = that requester's byte.
  - `o_tx_start` = 1.
  - `last_q` = `i_req_last[g]`.
  - Go to WAIT.
- Otherwise stay in FETCH indefinitely; the frame lock holds, with no timeout.

**Requesters**
- Requesters not granted see ready = 0.
- Their valid/data must be held stable until accepted.

**Status**
- `o_busy` = (state != IDLE).
- `o_timeout` clears only on reset.

**Reset (any state, including mid-frame)**
- State = IDLE.
- `o_tx_start`, `o_tx_data`, `o_grant`, `o_req_ready`, `o_busy`, `o_timeout`, `rr_ptr`, `last_q`, and the timeout counter are all 0.
- A partial frame is abandoned and no trailer is sent.

## Timing
- Valid seen in IDLE at cycle *c* produces `o_tx_start` = 1 with the header at *c+1*, and `o_grant` valid from *c+1*.
- `o_tx_start` is high for exactly one cycle per byte. It is never reasserted before `i_tx_done` or a timeout.
- `i_tx_done` coinciding with the `o_tx_start` cycle is ignored; counting starts the cycle after the start.
- `i_tx_done` at *d* puts FETCH at *d+1*. With the byte valid at *d+1*, the next `o_tx_start` is at *d+2*, so the minimum done-to-start gap is 2 cycles.
- Last-byte `i_tx_done` at *d* gives IDLE at *d+1*. The earliest next header start is *d+2*.
- Timeout fires when the counter reaches `TIMEOUT` (counter width `$clog2(TIMEOUT+1)`). If `i_tx_done` arrives in that same cycle, done wins and `o_timeout` is not set.
- `i_tx_done` seen outside WAIT is ignored.
- With N_REQ = 1, the header is `8'hA0` and arbitration is trivial.

## Structure
- Shared debug package holds:
  - `HDR_TAG` = 4'hA.
  - State encodings IDLE = 2'd0, WAIT = 2'd1, FETCH = 2'd2.
  - Requester ID constants: `REQ_DUMP` = 0, `REQ_ACK` = 1.
- One sub-module, `rr_picker`, is natural: combinational first-set-at-or-after-pointer over N_REQ bits, returning an index plus an any-valid flag.
- The FSM, counter, and output registers live in the top module.

## Test plan
- Single frame, N_REQ = 4: requester 2 sends bytes 0x11, 0x22 (last), with `i_tx_done` 10 cycles after each start.
  - Required: UART sees 0xA2, 0x11, 0x22; `o_grant` = 4'b0100 throughout; IDLE afterwards.
- Round-robin: requesters 0 and 1 both valid with 1-byte frames.
  - Required: first header 0xA0, next 0xA1; then with requester 0 valid again, 0xA0 is sent.
- Frame lock: requester 3 mid-frame stalls valid for 50 cycles while requester 0 is valid.
  - Required: no header for requester 0; `o_req_ready[0]` = 0; grant stays 4'b1000 until 3's last byte completes.
- Timeout: `TIMEOUT` = 16, `i_tx_done` never returns after the header.
  - Required: FETCH entered 16 cycles after the start is counted; `o_timeout` = 1 and sticky.
  - Done exactly at count 16: `o_timeout` stays 0.
- Reset mid-frame: assert `i_reset` in WAIT after the second byte.
  - Required: next cycle all outputs 0 and `o_busy` = 0.
  - Next grant starts from index 0.
- Done/start overlap: `i_tx_done` pulsed in the same cycle as `o_tx_start`.
  - Required: ignored; the block remains in WAIT.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared constants and types for the UART transmit arbiter
package uart_tx_arbiter_pkg;

  // Upper nibble of every frame header byte
  localparam logic [3:0] HDR_TAG = 4'hA;

  // Well-known requester slots
  localparam int REQ_DUMP = 0;
  localparam int REQ_ACK  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FETCH = 2'd2
  } arb_state_t;

  // Header byte announcing which requester owns the frame
  function automatic logic [7:0] hdr_byte(input logic [3:0] id);
    return {HDR_TAG, id};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rtl/uart_tx_arbiter_rr_picker.sv - first set request at or after a pointer, circular
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // Walk backwards so the closest candidate to ptr is the last one written
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        idx = IW'((int'(ptr) + k) % N_REQ);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, frame-locked sharing of one UART transmitter
module uart_tx_arbiter #(
  parameter int NB_DATA = 8,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data,
  input  logic [N_REQ-1:0]         i_req_last,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [NB_DATA-1:0]       o_tx_data,
  output logic                     o_tx_start,
  input  logic                     i_tx_done,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_busy,
  output logic                     o_timeout
);
  import uart_tx_arbiter_pkg::*;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t         state, state_n;
  logic [IW-1:0]      gidx_q, gidx_n;
  logic [N_REQ-1:0]   grant_q, grant_n;
  logic [NB_DATA-1:0] data_q, data_n;
  logic               start_q, start_n;
  logic               last_q, last_n;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic [IW-1:0]      ptr_q, ptr_n;
  logic               tout_q, tout_n;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req (i_req_valid),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state and next-output decisions; a byte ends on done or on counter expiry
  always_comb begin
    state_n = state;
    gidx_n  = gidx_q;
    grant_n = grant_q;
    data_n  = data_q;
    start_n = 1'b0;
    last_n  = last_q;
    cnt_n   = cnt_q;
    ptr_n   = ptr_q;
    tout_n  = tout_q;
    case (state)
      IDLE: begin
        if (pick_any) begin
          gidx_n  = pick_idx;
          grant_n = N_REQ'(1) << pick_idx;
          ptr_n   = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + IW'(1);
          data_n  = NB_DATA'(hdr_byte(4'(pick_idx)));
          start_n = 1'b1;
          last_n  = 1'b0;
          cnt_n   = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        // cnt equals the number of cycles elapsed since the start pulse
        cnt_n = cnt_q + CW'(1);
        // A done coinciding with the start pulse belongs to nothing we sent
        if (!start_q && (i_tx_done || cnt_q == CW'(TIMEOUT))) begin
          if (!i_tx_done) begin
            tout_n = 1'b1;
          end
          if (last_q) begin
            state_n = IDLE;
            grant_n = '0;
          end else begin
            state_n = FETCH;
          end
        end
      end
      FETCH: begin
        if (i_req_valid[gidx_q]) begin
          data_n  = i_req_data[int'(gidx_q)*NB_DATA +: NB_DATA];
          start_n = 1'b1;
          last_n  = i_req_last[gidx_q];
          cnt_n   = '0;
          state_n = WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers, all cleared by reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      gidx_q  <= '0;
      grant_q <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state   <= state_n;
      gidx_q  <= gidx_n;
      grant_q <= grant_n;
      data_q  <= data_n;
      start_q <= start_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
      ptr_q   <= ptr_n;
      tout_q  <= tout_n;
    end
  end

  assign o_req_ready = (state == FETCH) ? grant_q : '0;
  assign o_tx_data   = data_q;
  assign o_tx_start  = start_q;
  assign o_grant     = grant_q;
  assign o_busy      = (state != IDLE);
  assign o_timeout   = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench with a transaction-level model of the UART arbiter
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int NB = 8;
  localparam int NR = 4;
  localparam int TO = 16;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic [NR-1:0]     i_req_valid = '0;
  logic [NR*NB-1:0]  i_req_data = '0;
  logic [NR-1:0]     i_req_last = '0;
  logic              i_tx_done = 1'b0;
  logic [NR-1:0]     o_req_ready;
  logic [NB-1:0]     o_tx_data;
  logic              o_tx_start;
  logic [NR-1:0]     o_grant;
  logic              o_busy;
  logic              o_timeout;

  uart_tx_arbiter #(.NB_DATA(NB), .N_REQ(NR), .TIMEOUT(TO)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .i_tx_done   (i_tx_done),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Per-requester byte queues: bit 8 is the last flag
  logic [8:0] rq [NR][$];

  typedef struct packed {
    logic [7:0]    data;
    logic [NR-1:0] grant;
  } exp_t;
  exp_t       expq[$];
  logic [7:0] seen[$];
  logic       run = 1'b0;
  int         done_delay = 10;

  // Requester driver: present queue heads, pop a byte once valid&ready was seen
  initial begin : drv
    logic [NR-1:0] acc;
    logic [8:0]    ent;
    forever begin
      @(negedge i_clk);
      acc = i_req_valid & o_req_ready;
      @(posedge i_clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          ent = rq[i][0];
          i_req_valid[i] = 1'b1;
          i_req_data[i*NB +: NB] = ent[7:0];
          i_req_last[i] = ent[8];
        end else begin
          i_req_valid[i] = 1'b0;
          i_req_last[i]  = 1'b0;
        end
      end
    end
  end

  // UART responder: done_delay cycles after each start, negative means never
  initial begin : rsp
    forever begin
      @(negedge i_clk);
      if (o_tx_start && done_delay >= 0) begin
        repeat (done_delay) @(posedge i_clk);
        #1 i_tx_done = 1'b1;
        @(posedge i_clk);
        #1 i_tx_done = 1'b0;
      end
    end
  end

  // Model and compare: expected byte/owner sequence, one outstanding byte, timeout rule
  initial begin : cmp
    int   mcnt;
    logic outst, exp_to, chk_zero;
    exp_t e;
    mcnt = 0; outst = 1'b0; exp_to = 1'b0; chk_zero = 1'b0;
    forever begin
      @(negedge i_clk);
      if (run) begin
        if (chk_zero) begin
          chk("post_reset_start", o_tx_start, 0);
          chk("post_reset_data", o_tx_data, 0);
          chk("post_reset_grant", o_grant, 0);
          chk("post_reset_busy", o_busy, 0);
          chk("post_reset_timeout", o_timeout, 0);
          chk_zero = 1'b0;
        end
        chk("timeout_flag", o_timeout, exp_to);
        chk("busy_vs_owner", o_busy, |o_grant);
        chk("ready_outside_grant", o_req_ready & ~o_grant, 0);
        chk("grant_onehot", $countones(o_grant) <= 1, 1);
        if (o_tx_start) begin
          chk("start_while_pending", outst, 0);
          chk("start_expected", expq.size() > 0, 1);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("tx_byte", o_tx_data, e.data);
            chk("tx_owner", o_grant, e.grant);
          end
          seen.push_back(o_tx_data);
          outst = 1'b1;
          mcnt  = 0;
        end else if (outst) begin
          mcnt++;
          if (i_tx_done) outst = 1'b0;
          else if (mcnt == TO) begin
            exp_to = 1'b1;
            outst  = 1'b0;
          end
        end
        if (i_reset) begin
          expq.delete();
          outst = 1'b0; exp_to = 1'b0; chk_zero = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [NR-1:0] g);
    expq.push_back({d, g});
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    tick(3);
    for (int k = 0; k < 400; k++) begin
      if (!o_busy && rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
          rq[3].size() == 0 && expq.size() == 0) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    chk({name, "_idle"}, ok, 1);
  endtask

  task automatic wait_start(input string name);
    bit ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (o_tx_start) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    chk({name, "_start"}, ok, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    int cyc;
    bit ok;
    tick(3);
    chk("reset_start", o_tx_start, 0);
    chk("reset_data", o_tx_data, 0);
    chk("reset_grant", o_grant, 0);
    chk("reset_ready", o_req_ready, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_timeout", o_timeout, 0);
    i_reset = 1'b0;
    run = 1'b1;
    tick(2);

    // Single frame from requester 2
    base = seen.size();
    push_exp(8'hA2, 4'b0100); push_exp(8'h11, 4'b0100); push_exp(8'h22, 4'b0100);
    rq[2].push_back({1'b0, 8'h11});
    rq[2].push_back({1'b1, 8'h22});
    wait_start("t1");
    chk("t1_hdr", o_tx_data, 8'hA2);
    tick(12);
    chk("t1_gap_start", o_tx_start, 1);
    chk("t1_gap_data", o_tx_data, 8'h11);
    chk("t1_grant_mid", o_grant, 4'b0100);
    wait_idle("t1");
    chk("t1_seen0", seen[base], 8'hA2);
    chk("t1_seen1", seen[base+1], 8'h11);
    chk("t1_seen2", seen[base+2], 8'h22);
    chk("t1_grant_after", o_grant, 0);

    // Round robin between dump and ack requesters
    base = seen.size();
    push_exp(8'hA0, 4'b0001); push_exp(8'h30, 4'b0001);
    push_exp(8'hA1, 4'b0010); push_exp(8'h31, 4'b0010);
    rq[REQ_DUMP].push_back({1'b1, 8'h30});
    rq[REQ_ACK].push_back({1'b1, 8'h31});
    wait_idle("t2a");
    push_exp(8'hA0, 4'b0001); push_exp(8'h32, 4'b0001);
    rq[REQ_DUMP].push_back({1'b1, 8'h32});
    wait_idle("t2b");
    chk("t2_first_hdr", seen[base], 8'hA0);
    chk("t2_second_hdr", seen[base+2], 8'hA1);
    chk("t2_third_hdr", seen[base+4], 8'hA0);

    // Frame lock: requester 3 stalls while requester 0 waits
    base = seen.size();
    push_exp(8'hA3, 4'b1000); push_exp(8'h40, 4'b1000); push_exp(8'h41, 4'b1000);
    push_exp(8'hA0, 4'b0001); push_exp(8'h50, 4'b0001);
    rq[3].push_back({1'b0, 8'h40});
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (rq[3].size() == 0) begin ok = 1; break; end
      tick(1);
    end
    chk("t3_first_byte_taken", ok, 1);
    rq[0].push_back({1'b1, 8'h50});
    for (int k = 0; k < 50; k++) begin
      tick(1);
      chk("t3_grant_locked", o_grant, 4'b1000);
      chk("t3_ready0_low", o_req_ready[0], 0);
    end
    rq[3].push_back({1'b1, 8'h41});
    wait_idle("t3");
    chk("t3_trailer", seen[base+2], 8'h41);
    chk("t3_next_hdr", seen[base+3], 8'hA0);

    // Done arriving exactly at count TIMEOUT wins over the timeout
    done_delay = TO;
    push_exp(8'hA2, 4'b0100); push_exp(8'h66, 4'b0100);
    rq[2].push_back({1'b1, 8'h66});
    wait_idle("t4");
    chk("t4_no_timeout", o_timeout, 0);

    // Done overlapping the start is ignored, then the wait expires
    done_delay = 0;
    push_exp(8'hA1, 4'b0010); push_exp(8'h5C, 4'b0010);
    rq[1].push_back({1'b1, 8'h5C});
    wait_start("t5");
    chk("t5_hdr", o_tx_data, 8'hA1);
    tick(1);
    chk("t5_overlap_busy", o_busy, 1);
    chk("t5_overlap_ready", o_req_ready, 0);
    chk("t5_overlap_start", o_tx_start, 0);
    cyc = 1;
    while (o_req_ready == 0 && cyc < 40) begin
      tick(1);
      cyc++;
    end
    chk("t5_fetch_cycle", cyc, 17);
    chk("t5_timeout_set", o_timeout, 1);
    done_delay = 3;
    wait_idle("t5");
    chk("t5_timeout_sticky", o_timeout, 1);

    // Reset in the middle of a frame
    done_delay = 10;
    push_exp(8'hA0, 4'b0001); push_exp(8'h70, 4'b0001); push_exp(8'h71, 4'b0001);
    rq[0].push_back({1'b0, 8'h70});
    rq[0].push_back({1'b0, 8'h71});
    rq[0].push_back({1'b1, 8'h72});
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (o_tx_start && o_tx_data == 8'h71) begin ok = 1; break; end
      tick(1);
    end
    chk("t6_second_byte", ok, 1);
    tick(2);
    i_reset = 1'b1;
    rq[0].delete();
    tick(1);
    i_reset = 1'b0;
    chk("t6_start", o_tx_start, 0);
    chk("t6_data", o_tx_data, 0);
    chk("t6_grant", o_grant, 0);
    chk("t6_ready", o_req_ready, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_timeout", o_timeout, 0);
    tick(12);
    base = seen.size();
    push_exp(8'hA0, 4'b0001); push_exp(8'h80, 4'b0001);
    push_exp(8'hA1, 4'b0010); push_exp(8'h81, 4'b0010);
    rq[1].push_back({1'b1, 8'h81});
    rq[0].push_back({1'b1, 8'h80});
    wait_idle("t6");
    chk("t6_ptr_restart", seen[base], 8'hA0);

    chk("exp_queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
